// File: rtl/postprocess_linear_ctrl.sv
// Sequencer for the post-process linear layer: steps the weight-ROM address once per
// accepted feature and delays the feature qualifiers by the ROM read latency.
`timescale 1ns/1ps

module postprocess_linear_ctrl #(
   parameter int NUM_ITER = 64,
   parameter int ADDR_W   = 9,
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              start,
   input  logic              abort,
   input  logic              feat_valid,
   output logic              feat_ready,
   output logic              w_en,
   output logic [ADDR_W-1:0] iter,
   output logic              mac_valid,
   output logic              mac_first,
   output logic              mac_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ITER = ADDR_W'(NUM_ITER - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

   state_t state;
   tag_t   pipe [RD_LAT];
   tag_t   pipe_in;
   logic   accept;
   logic   pipe_busy;

   assign accept = feat_valid & feat_ready;
   assign w_en   = accept;

   always_comb begin
      pipe_in.valid = accept;
      pipe_in.first = accept && (iter == '0);
      pipe_in.last  = accept && (iter == LAST_ITER);
      pipe_busy     = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         pipe_busy = pipe_busy | pipe[i].valid;
      end
   end

   // feat_ready and busy are kept as flops updated alongside the state, so the
   // feature source sees a clean registered handshake.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= S_IDLE;
         iter       <= '0;
         feat_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state      <= S_IDLE;
            iter       <= '0;
            feat_ready <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state      <= S_RUN;
                     feat_ready <= 1'b1;
                     busy       <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (accept) begin
                     if (iter == LAST_ITER) begin
                        iter       <= '0;
                        state      <= S_DRAIN;
                        feat_ready <= 1'b0;
                     end else begin
                        iter <= iter + 1'b1;
                     end
                  end
               end
               S_DRAIN: begin
                  // The last term has left the pipe once no stage holds a valid tag.
                  if (!pipe_busy) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // NOTE: the delay pipe is a handful of flops rather than a RAM, so it is reset and
   // flushed explicitly; a stale valid bit would otherwise leak into the next pass.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else if (abort) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= pipe_in;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign mac_valid = pipe[RD_LAT-1].valid;
   assign mac_first = pipe[RD_LAT-1].first;
   assign mac_last  = pipe[RD_LAT-1].last;

endmodule

// File: tb/tb_postprocess_linear_ctrl.sv
// Bench for postprocess_linear_ctrl: three instances with different NUM_ITER/RD_LAT,
// each pass checked cycle by cycle against a term-schedule reference model.
`timescale 1ns/1ps

module tb_postprocess_linear_ctrl;

   logic       clk;
   logic       rst_b;
   logic [2:0] start_bus;
   logic       abort;
   logic       feat_valid;

   logic       fr [3];
   logic       wen [3];
   logic [8:0] it [3];
   logic       mv [3];
   logic       mf [3];
   logic       ml [3];
   logic       bsy [3];
   logic       dn [3];

   int n_checks = 0;
   int n_errors = 0;
   int sel = 0;

   logic       o_ready, o_wen, o_mv, o_mf, o_ml, o_busy, o_done;
   logic [8:0] o_iter;

   postprocess_linear_ctrl #(.NUM_ITER(64), .ADDR_W(9), .RD_LAT(1)) u_main (
      .clk(clk), .rst_b(rst_b), .start(start_bus[0]), .abort(abort),
      .feat_valid(feat_valid), .feat_ready(fr[0]), .w_en(wen[0]), .iter(it[0]),
      .mac_valid(mv[0]), .mac_first(mf[0]), .mac_last(ml[0]), .busy(bsy[0]), .done(dn[0]));

   postprocess_linear_ctrl #(.NUM_ITER(1), .ADDR_W(9), .RD_LAT(3)) u_single (
      .clk(clk), .rst_b(rst_b), .start(start_bus[1]), .abort(abort),
      .feat_valid(feat_valid), .feat_ready(fr[1]), .w_en(wen[1]), .iter(it[1]),
      .mac_valid(mv[1]), .mac_first(mf[1]), .mac_last(ml[1]), .busy(bsy[1]), .done(dn[1]));

   postprocess_linear_ctrl #(.NUM_ITER(512), .ADDR_W(9), .RD_LAT(2)) u_full (
      .clk(clk), .rst_b(rst_b), .start(start_bus[2]), .abort(abort),
      .feat_valid(feat_valid), .feat_ready(fr[2]), .w_en(wen[2]), .iter(it[2]),
      .mac_valid(mv[2]), .mac_first(mf[2]), .mac_last(ml[2]), .busy(bsy[2]), .done(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      o_ready = fr[0]; o_wen = wen[0]; o_iter = it[0]; o_mv = mv[0];
      o_mf = mf[0]; o_ml = ml[0]; o_busy = bsy[0]; o_done = dn[0];
      case (sel)
         1: begin
            o_ready = fr[1]; o_wen = wen[1]; o_iter = it[1]; o_mv = mv[1];
            o_mf = mf[1]; o_ml = ml[1]; o_busy = bsy[1]; o_done = dn[1];
         end
         2: begin
            o_ready = fr[2]; o_wen = wen[2]; o_iter = it[2]; o_mv = mv[2];
            o_mf = mf[2]; o_ml = ml[2]; o_busy = bsy[2]; o_done = dn[2];
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".busy"}, 32'(o_busy), 0);
      check({tag, ".feat_ready"}, 32'(o_ready), 0);
      check({tag, ".w_en"}, 32'(o_wen), 0);
      check({tag, ".iter"}, 32'(o_iter), 0);
      check({tag, ".mac_valid"}, 32'(o_mv), 0);
      check({tag, ".done"}, 32'(o_done), 0);
   endtask

   // Reference model: each accepted feature k becomes a MAC term due lat cycles later,
   // first for k==0, last for k==n-1; done follows lat+2 cycles after the last accept.
   // mode 0: feat_valid always high; 1: low every 3rd cycle; 2: random.
   task automatic run_pass(input int idx, input int n, input int lat, input int mode,
                           input int abort_k, input bit spurious, output int obs_done_c);
      bit exp_mv [4096];
      bit exp_mf [4096];
      bit exp_ml [4096];
      int k = 0, last_c = -1, abort_c = -1, done_c = -1;
      int n_mac = 0, n_done = 0, max_iter = 0;
      bit fv, ab, st, running, finished;
      string p;
      finished = 1'b0;
      obs_done_c = -1;
      sel = idx;
      foreach (exp_mv[i]) begin exp_mv[i] = 0; exp_mf[i] = 0; exp_ml[i] = 0; end
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         running = (c >= 1) && (k < n) && (abort_c < 0);
         case (mode)
            0: fv = 1'b1;
            1: fv = (c % 3) != 0;
            default: fv = $urandom_range(0, 3) != 0;
         endcase
         ab = (abort_k >= 0) && running && (k == abort_k);
         st = (c == 0) || (spurious && ((running && (c % 17) == 5) ||
                                        (last_c >= 0 && c == last_c + 1)));
         start_bus  = st ? 3'(1 << idx) : 3'b000;
         feat_valid = fv;
         abort      = ab;
         #1;
         p = $sformatf("u%0d@%0d", idx, c);
         check({p, ".busy"}, 32'(o_busy),
               32'((c >= 1) && (abort_c < 0 || c <= abort_c) && (done_c < 0 || c <= done_c)));
         check({p, ".feat_ready"}, 32'(o_ready), 32'(running));
         check({p, ".w_en"}, 32'(o_wen), 32'(running && fv));
         check({p, ".iter"}, 32'(o_iter), running ? 32'(k) : 0);
         check({p, ".mac_valid"}, 32'(o_mv), 32'(exp_mv[c]));
         if (exp_mv[c]) begin
            check({p, ".mac_first"}, 32'(o_mf), 32'(exp_mf[c]));
            check({p, ".mac_last"}, 32'(o_ml), 32'(exp_ml[c]));
         end
         check({p, ".done"}, 32'(o_done), 32'(c == done_c));
         if (o_mv === 1'b1) n_mac++;
         if (o_done === 1'b1) begin n_done++; if (obs_done_c < 0) obs_done_c = c; end
         if (int'(o_iter) > max_iter) max_iter = int'(o_iter);
         if (ab) begin
            abort_c = c;
            for (int j = c + 1; j < 4096; j++) exp_mv[j] = 0;
         end else if (running && fv) begin
            exp_mv[c + lat] = 1;
            exp_mf[c + lat] = (k == 0);
            exp_ml[c + lat] = (k == n - 1);
            k++;
            if (k == n) begin last_c = c; done_c = c + lat + 2; end
         end
         if ((done_c >= 0 && c == done_c + 2) || (abort_c >= 0 && c == abort_c + lat + 2)) begin
            finished = 1'b1;
            break;
         end
      end
      start_bus = '0; feat_valid = 1'b0; abort = 1'b0;
      check($sformatf("u%0d.pass_finished", idx), 32'(finished), 1);
      if (abort_c < 0) begin
         check($sformatf("u%0d.mac_count", idx), n_mac, n);
         check($sformatf("u%0d.done_count", idx), n_done, 1);
         check($sformatf("u%0d.max_iter", idx), max_iter, n - 1);
      end else begin
         check($sformatf("u%0d.done_after_abort", idx), n_done, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst_b = 1'b0; start_bus = '0; abort = 1'b0; feat_valid = 1'b0;

      // Reset state, with inputs active to show they are masked.
      #12;
      feat_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel = i; #1;
         check_idle($sformatf("reset_u%0d", i));
      end
      feat_valid = 1'b0;
      @(negedge clk); rst_b = 1'b1;

      // Streaming pass: done lands on cycle 67 after start.
      run_pass(0, 64, 1, 0, -1, 1'b0, dc);
      check("stream.done_cycle", dc, 67);

      // Bubbles every third cycle.
      run_pass(0, 64, 1, 1, -1, 1'b0, dc);

      // Abort at iter 30, then a clean pass.
      run_pass(0, 64, 1, 0, 30, 1'b0, dc);
      run_pass(0, 64, 1, 0, -1, 1'b0, dc);
      check("after_abort.done_cycle", dc, 67);

      // Spurious starts in RUN and DRAIN with random feature gaps.
      run_pass(0, 64, 1, 2, -1, 1'b1, dc);

      // start together with abort in IDLE.
      sel = 0;
      @(negedge clk); start_bus = 3'b001; abort = 1'b1;
      @(negedge clk); start_bus = '0; abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1; check($sformatf("start_abort_idle.busy%0d", i), 32'(o_busy), 0);
         check($sformatf("start_abort_idle.ready%0d", i), 32'(o_ready), 0);
         @(negedge clk);
      end

      // Single-term pass with three-cycle read latency.
      run_pass(1, 1, 3, 0, -1, 1'b0, dc);
      check("single.done_cycle", dc, 1 + 3 + 2);
      run_pass(1, 1, 3, 2, -1, 1'b1, dc);

      // Full 512-word ROM: iter reaches 511 then wraps.
      run_pass(2, 512, 2, 0, -1, 1'b0, dc);
      check("full.done_cycle", dc, 512 + 2 + 2);
      run_pass(2, 512, 2, 2, -1, 1'b1, dc);

      // Asynchronous reset mid-pass at iter 17.
      sel = 0;
      @(negedge clk); start_bus = 3'b001; feat_valid = 1'b1;
      @(negedge clk); start_bus = '0;
      repeat (17) @(negedge clk);
      #1;
      check("midreset.iter_before", 32'(o_iter), 17);
      check("midreset.busy_before", 32'(o_busy), 1);
      rst_b = 1'b0;
      #1;
      check_idle("midreset.during");
      check("midreset.mac_first", 32'(o_mf), 0);
      check("midreset.mac_last", 32'(o_ml), 0);
      @(negedge clk); rst_b = 1'b1; feat_valid = 1'b0;
      @(negedge clk); #1;
      check_idle("midreset.after");
      run_pass(0, 64, 1, 0, -1, 1'b0, dc);
      check("midreset.clean_done_cycle", dc, 67);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
